// File: rtl/cmp_pkg.sv
// Shared encodings for the serial magnitude comparator.
// Holds the FSM state codes and the internal 2-bit result code.
package cmp_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMP  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // RES_NONE marks "no result yet" so eq/lt/gt can all read 0.
    localparam logic [1:0] RES_NONE = 2'd0;
    localparam logic [1:0] RES_EQ   = 2'd1;
    localparam logic [1:0] RES_LT   = 2'd2;
    localparam logic [1:0] RES_GT   = 2'd3;

endpackage

// File: rtl/slice_cmp.sv
// Combinational compare of one SLICE-bit slice.
// Ports: xs/ys slice operands, invert_msb selects offset-binary
// handling of the slice MSB; s_eq = slices equal, s_lt = xs < ys.
module slice_cmp #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] xs,
    input  logic [SLICE-1:0] ys,
    input  logic             invert_msb,
    output logic             s_eq,
    output logic             s_lt
);

    logic [SLICE-1:0] msk;
    logic [SLICE-1:0] xm;
    logic [SLICE-1:0] ym;

    always_comb begin
        msk            = '0;
        msk[SLICE-1]   = invert_msb;
        xm             = xs ^ msk;
        ym             = ys ^ msk;
        s_eq           = &(~(xs ^ ys));
        s_lt           = (xm < ym);
    end

endmodule

// File: rtl/serial_mag_comparator.sv
// Multi-cycle eq/lt/gt comparator, SLICE bits per cycle, MSB first,
// stopping at the first differing slice.
// Ports: start/is_signed/a/b request a compare; busy/done handshake;
// eq/lt/gt result and slices_used (slices examined) hold until the
// next accepted start.
module serial_mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           is_signed,
    input  logic [WIDTH-1:0]               a,
    input  logic [WIDTH-1:0]               b,
    output logic                           busy,
    output logic                           done,
    output logic                           eq,
    output logic                           lt,
    output logic                           gt,
    output logic [$clog2(WIDTH/SLICE):0]   slices_used
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int SW     = $clog2(NSLICE) + 1;

    if (SLICE < 1 || SLICE > WIDTH) begin : g_bad_slice
        $error("SLICE must satisfy 1 <= SLICE <= WIDTH");
    end
    if (WIDTH % SLICE != 0) begin : g_bad_width
        $error("WIDTH must be a multiple of SLICE");
    end

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [1:0]       res_q, res_d;
    logic [SW-1:0]    used_q, used_d;

    logic [SLICE-1:0] xs;
    logic [SLICE-1:0] ys;
    logic             top_slice;
    logic             s_eq;
    logic             s_lt;

    // Slice select: one shared comparator fed by a mux.
    always_comb begin
        xs = '0;
        ys = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IW'(i)) begin
                xs = a_q[i*SLICE +: SLICE];
                ys = b_q[i*SLICE +: SLICE];
            end
        end
        top_slice = (idx_q == IW'(NSLICE - 1));
    end

    // Signed order equals unsigned order once the sign bit is flipped,
    // and only the top slice carries the sign bit.
    slice_cmp #(
        .SLICE (SLICE)
    ) u_slice_cmp (
        .xs         (xs),
        .ys         (ys),
        .invert_msb (sgn_q & top_slice),
        .s_eq       (s_eq),
        .s_lt       (s_lt)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        idx_d   = idx_q;
        res_d   = res_q;
        used_d  = used_q;
        case (state_q)
            ST_CMP: begin
                if (!s_eq) begin
                    res_d   = s_lt ? RES_LT : RES_GT;
                    used_d  = SW'(NSLICE - int'(idx_q));
                    state_d = ST_DONE;
                end else if (idx_q == '0) begin
                    res_d   = RES_EQ;
                    used_d  = SW'(NSLICE);
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sgn_d   = is_signed;
                    idx_d   = IW'(NSLICE - 1);
                    res_d   = RES_NONE;
                    used_d  = '0;
                    state_d = ST_CMP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            idx_q   <= '0;
            res_q   <= RES_NONE;
            used_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            used_q  <= used_d;
        end
    end

    assign busy        = (state_q == ST_CMP);
    assign done        = (state_q == ST_DONE);
    assign eq          = (res_q == RES_EQ);
    assign lt          = (res_q == RES_LT);
    assign gt          = (res_q == RES_GT);
    assign slices_used = used_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Self-checking bench for serial_mag_comparator (WIDTH=16, SLICE=4).
// Directed scenarios plus randomized operands against a reference model.
module tb_serial_mag_comparator;

    localparam int WIDTH  = 16;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              is_signed;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              busy;
    logic              done;
    logic              eq;
    logic              lt;
    logic              gt;
    logic [2:0]        slices_used;

    int checks   = 0;
    int failures = 0;

    serial_mag_comparator #(
        .WIDTH (WIDTH),
        .SLICE (SLICE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .eq          (eq),
        .lt          (lt),
        .gt          (gt),
        .slices_used (slices_used)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: result from integer ordering; slice count from the
    // position of the highest differing bit.
    function automatic void model(input logic [WIDTH-1:0] x,
                                  input logic [WIDTH-1:0] y,
                                  input logic s,
                                  output int n,
                                  output logic [2:0] r);
        logic [WIDTH-1:0] d;
        int hi;
        d  = x ^ y;
        hi = -1;
        for (int i = 0; i < WIDTH; i++) if (d[i]) hi = i;
        n = (hi < 0) ? NSLICE : NSLICE - hi / SLICE;
        if (s) begin
            if ($signed(x) < $signed(y))      r = 3'b010;
            else if ($signed(x) > $signed(y)) r = 3'b100;
            else                              r = 3'b001;
        end else begin
            if (x < y)      r = 3'b010;
            else if (x > y) r = 3'b100;
            else            r = 3'b001;
        end
    endfunction

    // Issue one compare and observe it; no checking here.
    task automatic do_op(input logic [WIDTH-1:0] ta,
                         input logic [WIDTH-1:0] tb2,
                         input logic ts,
                         input bit scramble,
                         output int cyc,
                         output int bcnt,
                         output logic [2:0] r,
                         output int used,
                         output int extra);
        @(negedge clk);
        a = ta; b = tb2; is_signed = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        bcnt = 0;
        while (!done && cyc < 40) begin
            if (busy) bcnt++;
            if (scramble) begin
                a = WIDTH'($urandom);
                b = WIDTH'($urandom);
                is_signed = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        r = {gt, lt, eq};
        used = int'(slices_used);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) extra++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, eq, lt, gt, slices_used} !== 8'd0) begin
            failures++;
            $display("FAIL reset_state: got %b required 0",
                     {busy, done, eq, lt, gt, slices_used});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, eq, lt, gt} !== 5'd0) begin
            failures++;
            $display("FAIL after_reset_idle: got %b required 0",
                     {busy, done, eq, lt, gt});
        end
    endtask

    task automatic check_op(input string nm,
                            input logic [WIDTH-1:0] ta,
                            input logic [WIDTH-1:0] tb2,
                            input logic ts,
                            input bit scramble);
        int cyc, bcnt, used, extra, n;
        logic [2:0] r, er;
        model(ta, tb2, ts, n, er);
        do_op(ta, tb2, ts, scramble, cyc, bcnt, r, used, extra);
        checks++;
        if (cyc !== n + 1 || bcnt !== n) begin
            failures++;
            $display("FAIL %s latency: got cyc=%0d busy=%0d required cyc=%0d busy=%0d",
                     nm, cyc, bcnt, n + 1, n);
        end
        checks++;
        if (r !== er) begin
            failures++;
            $display("FAIL %s result: a=%h b=%h s=%b got gt/lt/eq=%b required %b",
                     nm, ta, tb2, ts, r, er);
        end
        checks++;
        if (used !== n) begin
            failures++;
            $display("FAIL %s slices_used: got %0d required %0d", nm, used, n);
        end
        checks++;
        if (extra !== 0 || {gt, lt, eq} !== er) begin
            failures++;
            $display("FAIL %s hold: extra_done=%0d got %b required %b",
                     nm, extra, {gt, lt, eq}, er);
        end
    endtask

    task automatic test_directed();
        check_op("eq_1234", 16'h1234, 16'h1234, 1'b0, 1'b0);
        check_op("u_8000_7fff", 16'h8000, 16'h7FFF, 1'b0, 1'b0);
        check_op("s_8000_7fff", 16'h8000, 16'h7FFF, 1'b1, 1'b0);
        check_op("u_12a4_1234", 16'h12A4, 16'h1234, 1'b0, 1'b0);
        check_op("s_neg_eq", 16'hF00F, 16'hF00F, 1'b1, 1'b0);
        check_op("s_lowslice", 16'hFFF0, 16'hFFF7, 1'b1, 1'b0);
    endtask

    task automatic test_start_ignored();
        int extra;
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0000; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b1; a = 16'h0000; b = 16'hFFFF;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL ign_busy: got %b required 1", busy);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || {gt, lt, eq} !== 3'b100) begin
            failures++;
            $display("FAIL ign_result: done=%b gt/lt/eq=%b required 1 100",
                     done, {gt, lt, eq});
        end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL ign_single_done: got %0d extra busy/done required 0",
                     extra);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clk);
        a = 16'h8000; b = 16'h7FFF; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || {gt, lt, eq} !== 3'b100) begin
            failures++;
            $display("FAIL b2b_first: done=%b gt/lt/eq=%b required 1 100",
                     done, {gt, lt, eq});
        end
        a = 16'h0001; b = 16'h0002; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, done, gt, lt, eq} !== 5'b10000 || slices_used !== 3'd0) begin
            failures++;
            $display("FAIL b2b_accept: busy/done/gt/lt/eq=%b used=%0d required 10000 0",
                     {busy, done, gt, lt, eq}, slices_used);
        end
        cyc = 1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== 5 || {gt, lt, eq} !== 3'b010 || slices_used !== 3'd4) begin
            failures++;
            $display("FAIL b2b_second: cyc=%0d gt/lt/eq=%b used=%0d required 5 010 4",
                     cyc, {gt, lt, eq}, slices_used);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int seen;
        @(negedge clk);
        a = 16'h1234; b = 16'h1234; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, eq, lt, gt, slices_used} !== 8'd0) begin
            failures++;
            $display("FAIL async_reset: got %b required 0",
                     {busy, done, eq, lt, gt, slices_used});
        end
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL async_reset_no_done: got %0d done required 0", seen);
        end
        check_op("post_reset_aaaa", 16'hAAAA, 16'hAAAA, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] x, y;
        logic s;
        for (int i = 0; i < 40; i++) begin
            x = WIDTH'($urandom);
            s = 1'($urandom);
            case ($urandom % 4)
                0:       y = x;
                1:       y = x ^ (WIDTH'(1) << ($urandom % WIDTH));
                default: y = WIDTH'($urandom);
            endcase
            check_op("random", x, y, s, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_ignored();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
